// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADDR_W = 12;

    // Access size encoding, shared by funct3[1:0] and the dmem word port
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam int unsigned F3_SIZE_LO  = 0;
    localparam int unsigned F3_SIZE_HI  = 1;
    localparam int unsigned F3_UNSIGNED = 2;

    // Legacy-compatible FSM encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // True when the low address bits break natural alignment for the size
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            SZ_D:    return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake bundle between the memory stage and the LSU.
interface lsu_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of raw little-endian load data according to funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext_c
);

    logic fill_b, fill_h, fill_w;

    assign fill_b = ~funct3[F3_UNSIGNED] & raw[7];
    assign fill_h = ~funct3[F3_UNSIGNED] & raw[15];
    assign fill_w = ~funct3[F3_UNSIGNED] & raw[31];

    // Doubleword (and the 111 encoding) pass through untouched
    always_comb begin
        ext_c = raw;
        case (funct3[F3_SIZE_HI:F3_SIZE_LO])
            SZ_B:    ext_c = {{(XLEN-8){fill_b}},  raw[7:0]};
            SZ_H:    ext_c = {{(XLEN-16){fill_h}}, raw[15:0]};
            SZ_W:    ext_c = {{(XLEN-32){fill_w}}, raw[31:0]};
            default: ext_c = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store unit driving dmem: IDLE -> ACCESS -> RESP.
// Optional LSU_ALIGN_CHECK_EN: misaligned accesses are suppressed and reported via resp_err.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    lsu_if.slave              bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_dataw,
    output logic [1:0]        mem_word,
    output logic              mem_rw,
    input  logic [XLEN-1:0]   mem_datar
);

    logic [1:0]        state, state_nxt;
    logic              req_ready_q, req_ready_nxt;
    logic              resp_valid_q, resp_valid_nxt;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_nxt;
    logic              resp_err_q, resp_err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [XLEN-1:0]   mem_dataw_nxt;
    logic [1:0]        mem_word_nxt;
    logic              mem_rw_nxt;
    logic              we_q, we_nxt;
    logic [2:0]        funct3_q, funct3_nxt;
    logic              fault_q, fault_nxt;

    lsu_req_t          req_c;
    logic              accept;
    logic              fault_c;
    logic [XLEN-1:0]   ext_c;
    logic              unused_addr_hi;

    assign req_c = '{we: bus.req_we, funct3: bus.req_funct3,
                     addr: bus.req_addr, wdata: bus.req_wdata};
    assign accept = bus.req_valid & req_ready_q;
    // dmem only sees the low ADDR_W bits; the rest are dropped by design
    assign unused_addr_hi = ^req_c.addr[XLEN-1:ADDR_W];

`ifdef LSU_ALIGN_CHECK_EN
    assign fault_c = misaligned(req_c.funct3[F3_SIZE_HI:F3_SIZE_LO], req_c.addr[2:0]);
`else
    assign fault_c = 1'b0;
`endif

    lsu_load_ext u_load_ext (
        .raw    (mem_datar),
        .funct3 (funct3_q),
        .ext_c  (ext_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr     <= '0;
            mem_dataw    <= '0;
            mem_word     <= '0;
            mem_rw       <= 1'b0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            fault_q      <= 1'b0;
        end else begin
            state        <= state_nxt;
            req_ready_q  <= req_ready_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_rdata_q <= resp_rdata_nxt;
            resp_err_q   <= resp_err_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_dataw    <= mem_dataw_nxt;
            mem_word     <= mem_word_nxt;
            mem_rw       <= mem_rw_nxt;
            we_q         <= we_nxt;
            funct3_q     <= funct3_nxt;
            fault_q      <= fault_nxt;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_nxt      = state;
        req_ready_nxt  = req_ready_q;
        resp_valid_nxt = resp_valid_q;
        resp_rdata_nxt = resp_rdata_q;
        resp_err_nxt   = resp_err_q;
        mem_addr_nxt   = mem_addr;
        mem_dataw_nxt  = mem_dataw;
        mem_word_nxt   = mem_word;
        mem_rw_nxt     = 1'b0;
        we_nxt         = we_q;
        funct3_nxt     = funct3_q;
        fault_nxt      = fault_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = ACCESS;
                    req_ready_nxt = 1'b0;
                    mem_addr_nxt  = req_c.addr[ADDR_W-1:0];
                    mem_dataw_nxt = req_c.wdata;
                    mem_word_nxt  = req_c.funct3[F3_SIZE_HI:F3_SIZE_LO];
                    mem_rw_nxt    = req_c.we & ~fault_c;
                    we_nxt        = req_c.we;
                    funct3_nxt    = req_c.funct3;
                    fault_nxt     = fault_c;
                end
            end
            ACCESS: begin
                // Read data is captured at the same edge that commits a store
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
                resp_err_nxt   = fault_q;
                resp_rdata_nxt = (we_q | fault_q) ? '0 : ext_c;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt      = IDLE;
                    resp_valid_nxt = 1'b0;
                    req_ready_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule
